// File: rtl/regfile_pkg.sv
// ============================================================================
// Module : rvcpu (package)
// Brief  : Shared register-index type and constants for the rvcpu core.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rvcpu;

  typedef logic [4:0] reg_t;

  localparam int   NumRegs = 32;
  localparam reg_t RegZero = 5'd0;

endpackage

`default_nettype wire

// File: rtl/regfile_read_port.sv
// ============================================================================
// Module : regfile_read_port
// Brief  : One combinational read port with index mux, x0/valid zero gating
//          and optional write forwarding (REGFILE_BYPASS_EN).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_read_port
  import rvcpu::*;
#(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = NumRegs
) (
  input  logic [NUM_REGS-1:0][WIDTH-1:0] i_regs,
  input  reg_t                           i_rs,
  input  logic                           i_rs_valid,
  input  logic                           i_reset,
  input  reg_t                           i_rw,
  input  logic                           i_rw_valid,
  input  logic [WIDTH-1:0]               i_wval,
  output logic [WIDTH-1:0]               o_rd
);

  logic w_zero;
  logic w_bypass;

  assign w_zero = !i_rs_valid || (i_rs == RegZero);

`ifdef REGFILE_BYPASS_EN
  // Forwarding is held off during reset so the read reflects stored state.
  assign w_bypass = i_rw_valid && !i_reset && (i_rw == i_rs);
`else
  logic w_unused_bypass;
  assign w_unused_bypass = &{1'b0, i_reset, i_rw, i_rw_valid};
  assign w_bypass        = 1'b0;
`endif

  always_comb begin
    o_rd = '0;
    if (!w_zero) begin
      o_rd = w_bypass ? i_wval : i_regs[i_rs];
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile.sv
// ============================================================================
// Module : regfile
// Brief  : 32 x Width integer register file, two combinational read ports,
//          one write port, x0 hardwired to zero. Macro: REGFILE_BYPASS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile
  import rvcpu::*;
#(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = NumRegs
) (
  input  logic             clk,
  input  logic             reset,
  input  reg_t             rs1,
  input  logic             rs1_valid,
  input  reg_t             rs2,
  input  logic             rs2_valid,
  input  reg_t             rw,
  input  logic             rw_valid,
  input  logic [WIDTH-1:0] wval,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2
);

  logic [NUM_REGS-1:0][WIDTH-1:0] r_regs;

  // Reset wins over a same-cycle write; x0 is never written so it stays 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_regs <= '0;
    end else if (rw_valid && (rw != RegZero)) begin
      r_regs[rw] <= wval;
    end
  end

  regfile_read_port #(
    .WIDTH    (WIDTH),
    .NUM_REGS (NUM_REGS)
  ) u_rd_port1 (
    .i_regs     (r_regs),
    .i_rs       (rs1),
    .i_rs_valid (rs1_valid),
    .i_reset    (reset),
    .i_rw       (rw),
    .i_rw_valid (rw_valid),
    .i_wval     (wval),
    .o_rd       (rd1)
  );

  regfile_read_port #(
    .WIDTH    (WIDTH),
    .NUM_REGS (NUM_REGS)
  ) u_rd_port2 (
    .i_regs     (r_regs),
    .i_rs       (rs2),
    .i_rs_valid (rs2_valid),
    .i_reset    (reset),
    .i_rw       (rw),
    .i_rw_valid (rw_valid),
    .i_wval     (wval),
    .o_rd       (rd2)
  );

endmodule

`default_nettype wire

// File: tb/tb_regfile.sv
// ============================================================================
// Module : tb_regfile
// Brief  : Scoreboard bench for regfile; honours REGFILE_BYPASS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile;

  logic        clk;
  logic        reset;
  logic [4:0]  rs1, rs2, rw;
  logic        rs1_valid, rs2_valid, rw_valid;
  logic [31:0] wval;
  logic [31:0] rd1, rd2;

  logic [31:0] q_e1[$];
  logic [31:0] q_e2[$];
  string       q_nm[$];

  int errors = 0;
  int checks = 0;
  bit done   = 0;

  regfile dut (
    .clk       (clk),
    .reset     (reset),
    .rs1       (rs1),
    .rs1_valid (rs1_valid),
    .rs2       (rs2),
    .rs2_valid (rs2_valid),
    .rw        (rw),
    .rw_valid  (rw_valid),
    .wval      (wval),
    .rd1       (rd1),
    .rd2       (rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_rd(input logic [31:0] e1, input logic [31:0] e2, input string nm);
    q_e1.push_back(e1);
    q_e2.push_back(e2);
    q_nm.push_back(nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a1, input logic v1, input logic [4:0] a2, input logic v2);
    rs1 = a1; rs1_valid = v1; rs2 = a2; rs2_valid = v2;
  endtask

  task automatic wr(input logic [4:0] a, input logic v, input logic [31:0] d);
    rw = a; rw_valid = v; wval = d;
  endtask

  // Monitor: compares DUT outputs mid-cycle against queued expectations.
  initial begin
    logic [31:0] e1, e2;
    string nm;
    forever begin
      @(negedge clk);
      while (q_e1.size() > 0) begin
        e1 = q_e1.pop_front();
        e2 = q_e2.pop_front();
        nm = q_nm.pop_front();
        checks++;
        if (rd1 !== e1 || rd2 !== e2) begin
          errors++;
          $display("FAIL %s: rd1=%h rd2=%h expected rd1=%h rd2=%h", nm, rd1, rd2, e1, e2);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    rd(5'd0, 1'b0, 5'd0, 1'b0);
    wr(5'd0, 1'b0, 32'd0);
    step();
    step();
    reset = 1'b0;
    rd(5'd1, 1'b1, 5'd31, 1'b1);
    expect_rd(32'd0, 32'd0, "reset_read");
    step();

    rd(5'd1, 1'b0, 5'd31, 1'b0);
    wr(5'd1, 1'b1, 32'd123);
    expect_rd(32'd0, 32'd0, "invalid_ports_zero");
    step();
    wr(5'd0, 1'b0, 32'd0);
    rd(5'd1, 1'b1, 5'd31, 1'b1);
    expect_rd(32'd123, 32'd0, "write_x1");
    step();

    wr(5'd0, 1'b1, 32'hDEADBEEF);
    rd(5'd0, 1'b1, 5'd1, 1'b1);
    expect_rd(32'd0, 32'd123, "x0_write_cycle");
    step();
    wr(5'd0, 1'b0, 32'd0);
    expect_rd(32'd0, 32'd123, "x0_immutable");
    step();

    wr(5'd2, 1'b1, 32'd456);
    rd(5'd0, 1'b0, 5'd0, 1'b0);
    step();
    wr(5'd0, 1'b0, 32'd0);
    rd(5'd2, 1'b1, 5'd1, 1'b1);
    expect_rd(32'd456, 32'd123, "two_ports");
    step();
    rs1_valid = 1'b0;
    expect_rd(32'd0, 32'd123, "rs1_deassert");
    step();
    rd(5'd2, 1'b1, 5'd2, 1'b1);
    expect_rd(32'd456, 32'd456, "same_index");
    step();

    wr(5'd5, 1'b1, 32'd77);
    rd(5'd5, 1'b1, 5'd2, 1'b1);
`ifdef REGFILE_BYPASS_EN
    expect_rd(32'd77, 32'd456, "raw_same_cycle");
`else
    expect_rd(32'd0, 32'd456, "raw_same_cycle");
`endif
    step();
    wr(5'd0, 1'b0, 32'd0);
    expect_rd(32'd77, 32'd456, "raw_after_edge");
    step();

    wr(5'd5, 1'b0, 32'd1234);
    step();
    wr(5'd0, 1'b0, 32'd0);
    expect_rd(32'd77, 32'd456, "wen_low_no_change");
    step();

    rd(5'd0, 1'b0, 5'd0, 1'b0);
    for (int i = 1; i < 32; i++) begin
      wr(i[4:0], 1'b1, i);
      step();
    end
    wr(5'd0, 1'b0, 32'd0);
    rd(5'd31, 1'b1, 5'd17, 1'b1);
    expect_rd(32'd31, 32'd17, "fill_read_a");
    step();
    rd(5'd3, 1'b1, 5'd4, 1'b1);
    expect_rd(32'd3, 32'd4, "fill_read_b");
    step();

    reset = 1'b1;
    wr(5'd3, 1'b1, 32'd999);
    expect_rd(32'd3, 32'd4, "reset_cycle_old_data");
    step();
    reset = 1'b0;
    wr(5'd0, 1'b0, 32'd0);
    expect_rd(32'd0, 32'd0, "reset_beats_write");
    step();
    for (int i = 1; i < 32; i += 6) begin
      rd(i[4:0], 1'b1, 5'(31 - i), 1'b1);
      expect_rd(32'd0, 32'd0, "cleared_after_reset");
      step();
    end

    done = 1'b1;
    for (int n = 0; n < 10 && q_e1.size() > 0; n++) step();
    if (q_e1.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d pending expectations, required 0", q_e1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
